// File: rtl/fft_in_ctrl_pkg.sv
// Shared FFT definitions: default frame geometry and the per-bank state encoding
// used by the input controller and reusable by the butterfly core.
package fft_in_ctrl_pkg;

    localparam int FFT_TOTAL_STAGE = 10;
    localparam int FFT_CPLX_WIDTH  = 32;
    localparam int FFT_N           = 1 << FFT_TOTAL_STAGE;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_BUSY    = 2'd3
    } bank_st_e;

endpackage

// File: rtl/fft_in_ctrl_bitrev_addr.sv
// fft_bitrev_addr: combinational reversal of a TOTAL_STAGE-bit sample index
// into the RAM address of the bit-reversed input ordering.
module fft_bitrev_addr
    import fft_in_ctrl_pkg::*;
#(
    parameter int TOTAL_STAGE = FFT_TOTAL_STAGE
) (
    input  logic [TOTAL_STAGE-1:0] din,
    output logic [TOTAL_STAGE-1:0] dout
);

    // Mirror the index bits: dout[MSB-i] takes din[i].
    always_comb begin
        dout = {TOTAL_STAGE{1'b0}};
        for (int i = 0; i < TOTAL_STAGE; i++) begin
            dout[TOTAL_STAGE-1-i] = din[i];
        end
    end

endmodule

// File: rtl/fft_in_ctrl.sv
// fft_in_ctrl: writes a natural-order sample stream bit-reversed into a ping-pong
// input RAM and hands full banks to the FFT core. FFT_IN_CTRL_DROP_CNT_EN adds drop_cnt/ovf.
module fft_in_ctrl
    import fft_in_ctrl_pkg::*;
#(
    parameter int TOTAL_STAGE = FFT_TOTAL_STAGE,
    parameter int CPLX_WIDTH  = FFT_CPLX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ien,
    output logic                   iready,
    input  logic [CPLX_WIDTH-1:0]  idata,
    output logic                   wen,
    output logic                   wbank,
    output logic [TOTAL_STAGE-1:0] waddr,
    output logic [CPLX_WIDTH-1:0]  wdata,
    output logic                   frm_valid,
    output logic                   frm_bank,
    input  logic                   frm_ack,
    input  logic                   frm_done
`ifdef FFT_IN_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt,
    output logic                   ovf
`endif
);

    localparam logic [TOTAL_STAGE-1:0] CNT_LAST = {TOTAL_STAGE{1'b1}};
    localparam logic [TOTAL_STAGE-1:0] CNT_ONE  = {{(TOTAL_STAGE-1){1'b0}}, 1'b1};

    bank_st_e               bank_st_r [2];
    bank_st_e               bank_st_s [2];
    logic [TOTAL_STAGE-1:0] cnt_r;
    logic [TOTAL_STAGE-1:0] cnt_s;
    logic [TOTAL_STAGE-1:0] cnt_rev_s;
    logic                   fbank_r;
    logic                   fbank_s;
    logic                   iready_s;
    logic                   accept_s;
    logic                   frm_valid_s;
    logic                   frm_bank_s;

    fft_bitrev_addr #(
        .TOTAL_STAGE (TOTAL_STAGE)
    ) u_bitrev (
        .din  (cnt_r),
        .dout (cnt_rev_s)
    );

    assign iready_s = !rst && ((bank_st_r[fbank_r] == BANK_FREE) ||
                               (bank_st_r[fbank_r] == BANK_FILLING));
    assign accept_s = ien && iready_s;
    assign iready   = iready_s;

    // Next bank states (release first, then grant, then fill), fill pointer and frame offer.
    always_comb begin
        bank_st_s[0] = bank_st_r[0];
        bank_st_s[1] = bank_st_r[1];
        cnt_s        = cnt_r;
        fbank_s      = fbank_r;
        frm_valid_s  = 1'b0;
        frm_bank_s   = frm_bank;

        for (int b = 0; b < 2; b++) begin
            case (bank_st_r[b])
                BANK_BUSY: begin
                    if (frm_done) bank_st_s[b] = BANK_FREE;
                    else          bank_st_s[b] = BANK_BUSY;
                end
                BANK_FULL: begin
                    if (frm_valid && frm_ack && (int'(frm_bank) == b)) bank_st_s[b] = BANK_BUSY;
                    else                                               bank_st_s[b] = BANK_FULL;
                end
                default: bank_st_s[b] = bank_st_r[b];
            endcase
        end

        if (accept_s) begin
            cnt_s = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) bank_st_s[fbank_r] = BANK_FULL;
            else                   bank_st_s[fbank_r] = BANK_FILLING;
        end else begin
            cnt_s = cnt_r;
        end

        // Move the fill pointer as soon as the current bank is closed and the other one is free.
        if (((bank_st_s[fbank_r] == BANK_FULL) || (bank_st_s[fbank_r] == BANK_BUSY)) &&
            (bank_st_s[~fbank_r] == BANK_FREE)) begin
            fbank_s = ~fbank_r;
        end else begin
            fbank_s = fbank_r;
        end

        if (frm_valid) begin
            frm_valid_s = !frm_ack;
            frm_bank_s  = frm_bank;
        end else begin
            frm_valid_s = ((bank_st_r[0] == BANK_FULL) || (bank_st_r[1] == BANK_FULL)) &&
                          (bank_st_r[0] != BANK_BUSY) && (bank_st_r[1] != BANK_BUSY);
            // With both banks full the fill pointer sits on the newer one.
            if ((bank_st_r[0] == BANK_FULL) && (bank_st_r[1] == BANK_FULL)) begin
                frm_bank_s = ~fbank_r;
            end else begin
                frm_bank_s = (bank_st_r[1] == BANK_FULL);
            end
        end
    end

    // State registers and the registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st_r[0] <= BANK_FREE;
            bank_st_r[1] <= BANK_FREE;
            cnt_r        <= {TOTAL_STAGE{1'b0}};
            fbank_r      <= 1'b0;
            wen          <= 1'b0;
            wbank        <= 1'b0;
            waddr        <= {TOTAL_STAGE{1'b0}};
            wdata        <= {CPLX_WIDTH{1'b0}};
            frm_valid    <= 1'b0;
            frm_bank     <= 1'b0;
        end else begin
            bank_st_r[0] <= bank_st_s[0];
            bank_st_r[1] <= bank_st_s[1];
            cnt_r        <= cnt_s;
            fbank_r      <= fbank_s;
            wen          <= accept_s;
            if (accept_s) begin
                wbank <= fbank_r;
                waddr <= cnt_rev_s;
                wdata <= idata;
            end
            frm_valid    <= frm_valid_s;
            frm_bank     <= frm_bank_s;
        end
    end

`ifdef FFT_IN_CTRL_DROP_CNT_EN
    // Saturating count of cycles where the source presented a sample that could not be taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'h0000;
            ovf      <= 1'b0;
        end else if (ien && !iready_s && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
            if (drop_cnt == 16'hFFFE) ovf <= 1'b1;
        end
    end
`endif

endmodule
